// File: rtl/lap_time_bcd.sv
// Round-robin binary-to-BCD converter for the current, last and best lap times.
// A single shift-add-3 engine serves all three channels; each output holds until its next store.
module lap_time_bcd #(
  parameter int unsigned SAT_VALUE = 9999
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [15:0] current_lap_time,
  input  logic [15:0] last_lap_time,
  input  logic [15:0] best_lap_time,
  output logic [15:0] cur_bcd,
  output logic [15:0] last_bcd,
  output logic [15:0] best_bcd,
  output logic        digits_valid,
  output logic        round_done
);

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] STORE = 2'd2;

  localparam logic [15:0] SAT = 16'(SAT_VALUE);

  logic [1:0]  state;
  logic [1:0]  ch;
  logic [1:0]  ch_eff;
  logic [4:0]  cnt;
  logic [15:0] bin;
  logic [15:0] bcd;
  logic [15:0] sel;
  logic [15:0] sat;
  logic [15:0] adj;

  // Channel index 3 is unreachable; treat it as channel 0 if it ever appears.
  assign ch_eff = (ch == 2'd3) ? 2'd0 : ch;

  always_comb begin
    sel = current_lap_time;
    case (ch_eff)
      2'd1:    sel = last_lap_time;
      2'd2:    sel = best_lap_time;
      default: sel = current_lap_time;
    endcase
    sat = (sel > SAT) ? SAT : sel;
  end

  always_comb begin
    adj = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state        <= LOAD;
      ch           <= 2'd0;
      cnt          <= '0;
      bin          <= '0;
      bcd          <= '0;
      cur_bcd      <= '0;
      last_bcd     <= '0;
      best_bcd     <= '0;
      digits_valid <= 1'b0;
      round_done   <= 1'b0;
    end else begin
      round_done <= 1'b0;
      case (state)
        LOAD: begin
          bin   <= sat;
          bcd   <= '0;
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          // {bcd, bin} shifted left as one 32-bit word after the add-3 correction.
          bcd <= {adj[14:0], bin[15]};
          bin <= {bin[14:0], 1'b0};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd15) state <= STORE;
        end
        STORE: begin
          case (ch_eff)
            2'd0: cur_bcd  <= bcd;
            2'd1: last_bcd <= bcd;
            default: begin
              best_bcd     <= bcd;
              digits_valid <= 1'b1;
              round_done   <= 1'b1;
            end
          endcase
          ch    <= (ch_eff == 2'd2) ? 2'd0 : ch_eff + 2'd1;
          state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_lap_time_bcd.sv
// Directed bench for lap_time_bcd: vector table, timing corner sequences and a strided sweep
// checked against a decimal-split reference.
module tb_lap_time_bcd;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic [15:0] current_lap_time = '0;
  logic [15:0] last_lap_time    = '0;
  logic [15:0] best_lap_time    = '0;
  logic [15:0] cur_bcd, last_bcd, best_bcd;
  logic        digits_valid, round_done;

  int applied = 0;
  int miscompares = 0;
  int cyc = 0;

  lap_time_bcd #(.SAT_VALUE(9999)) dut (
    .pclk(pclk),
    .rst(rst),
    .current_lap_time(current_lap_time),
    .last_lap_time(last_lap_time),
    .best_lap_time(best_lap_time),
    .cur_bcd(cur_bcd),
    .last_bcd(last_bcd),
    .best_bcd(best_bcd),
    .digits_valid(digits_valid),
    .round_done(round_done)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int          cur;
    int          last;
    int          best;
    logic [15:0] exp_cur;
    logic [15:0] exp_last;
    logic [15:0] exp_best;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [15:0] ref_bcd(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Leaves the bench at the negedge of cycle 0 with rst low.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge pclk);
    check("reset cur_bcd", cur_bcd, 16'h0000);
    check("reset last_bcd", last_bcd, 16'h0000);
    check("reset best_bcd", best_bcd, 16'h0000);
    check("reset digits_valid", {15'd0, digits_valid}, 16'd0);
    check("reset round_done", {15'd0, round_done}, 16'd0);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(negedge pclk);
      cyc++;
    end
  endtask

  task automatic drive(input int c, input int l, input int b);
    current_lap_time = 16'(c);
    last_lap_time    = 16'(l);
    best_lap_time    = 16'(b);
  endtask

  initial begin
    vecs[0] = '{4000, 999, 101, 16'h4000, 16'h0999, 16'h0101};
    vecs[1] = '{9999, 10000, 65535, 16'h9999, 16'h9999, 16'h9999};
    vecs[2] = '{0, 1, 10, 16'h0000, 16'h0001, 16'h0010};
    vecs[3] = '{59, 600, 9998, 16'h0059, 16'h0600, 16'h9998};
    vecs[4] = '{1234, 5678, 9090, 16'h1234, 16'h5678, 16'h9090};

    // Basic timing with current = 1234.
    drive(1234, 0, 0);
    do_reset();
    goto(17);
    check("cur not yet stored", cur_bcd, 16'h0000);
    goto(18);
    check("cur first valid", cur_bcd, 16'h1234);
    check("last idle", last_bcd, 16'h0000);
    goto(53);
    check("digits_valid before 54", {15'd0, digits_valid}, 16'd0);
    check("round_done before 54", {15'd0, round_done}, 16'd0);
    goto(54);
    check("digits_valid at 54", {15'd0, digits_valid}, 16'd1);
    check("round_done at 54", {15'd0, round_done}, 16'd1);
    check("best zero", best_bcd, 16'h0000);
    goto(55);
    check("round_done after 54", {15'd0, round_done}, 16'd0);
    check("digits_valid sticky", {15'd0, digits_valid}, 16'd1);

    // Vector table, one full round each; first vector also watches round_done over two rounds.
    for (int v = 0; v < 5; v++) begin
      drive(vecs[v].cur, vecs[v].last, vecs[v].best);
      do_reset();
      if (v == 0) begin
        for (int c = 1; c <= 110; c++) begin
          goto(c);
          check("round_done pulse", {15'd0, round_done}, (c == 54 || c == 108) ? 16'd1 : 16'd0);
        end
      end
      goto(v == 0 ? 110 : 54);
      check("vec cur_bcd", cur_bcd, vecs[v].exp_cur);
      check("vec last_bcd", last_bcd, vecs[v].exp_last);
      check("vec best_bcd", best_bcd, vecs[v].exp_best);
      check("vec digits_valid", {15'd0, digits_valid}, 16'd1);
    end

    // Input change mid-SHIFT only affects the next conversion.
    drive(500, 0, 0);
    do_reset();
    goto(5);
    current_lap_time = 16'd501;
    goto(18);
    check("midshift old value", cur_bcd, 16'h0500);
    goto(71);
    check("midshift still old", cur_bcd, 16'h0500);
    goto(72);
    check("midshift new value", cur_bcd, 16'h0501);

    // Reset during the ch 1 conversion.
    drive(1234, 999, 101);
    do_reset();
    goto(39);
    check("pre-abort cur", cur_bcd, 16'h1234);
    goto(40);
    rst = 1'b1;
    goto(41);
    check("abort cur_bcd", cur_bcd, 16'h0000);
    check("abort last_bcd", last_bcd, 16'h0000);
    check("abort best_bcd", best_bcd, 16'h0000);
    check("abort digits_valid", {15'd0, digits_valid}, 16'd0);
    rst = 1'b0;
    cyc = 0;
    goto(17);
    check("restart cur early", cur_bcd, 16'h0000);
    goto(18);
    check("restart cur", cur_bcd, 16'h1234);
    goto(36);
    check("restart last", last_bcd, 16'h0999);

    // Strided sweep: new triple every round, sampled by the next round.
    drive(0, 7, 13);
    do_reset();
    for (int k = 0; k <= 500; k++) begin
      int c, l, b;
      goto(54 * (k + 1));
      c = (k == 500) ? 9999 : k * 20;
      l = (k == 500) ? 9997 : k * 20 + 7;
      b = (k == 500) ? 9998 : k * 20 + 13;
      check("sweep cur", cur_bcd, ref_bcd(int'(current_lap_time)));
      check("sweep last", last_bcd, ref_bcd(int'(last_lap_time)));
      check("sweep best", best_bcd, ref_bcd(int'(best_lap_time)));
      if (k < 500) drive(c + 20, l + 20, b + 20);
      if (k == 499) drive(9999, 9997, 9998);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
